// File: rtl/song_player.sv
// song_player: two-song auto-play sequencer driving a one-hot note vector.
// Define SONG_PLAYER_LOOP_EN to repeat the song until play drops.
module song_player #(
    parameter int unsigned TICKS_PER_BEAT = 12500000,
    parameter int unsigned GAP_TICKS      = 1250000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       play,
    input  logic       song_sel,
    output logic [7:0] note_sw,
    output logic [5:0] note_pos,
    output logic       busy,
    output logic       done
);
    // state | meaning
    // IDLE  | silent, waiting for a rising edge on play
    // NOTE  | sounding the current entry for beats*TICKS_PER_BEAT cycles
    // GAP   | silence after a note for GAP_TICKS cycles
    typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

    localparam int CW = $clog2(3 * TICKS_PER_BEAT + 1);
    localparam logic [CW-1:0] GAP_LOAD = (GAP_TICKS > 0) ? CW'(GAP_TICKS - 1) : '0;

    localparam logic [3:0] N_C = 4'd1;
    localparam logic [3:0] N_D = 4'd2;
    localparam logic [3:0] N_E = 4'd3;
    localparam logic [3:0] N_F = 4'd4;
    localparam logic [3:0] N_G = 4'd5;

    localparam logic [5:0] LAST_SONG0 = 6'd29;
    localparam logic [5:0] LAST_SONG1 = 6'd6;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [5:0]    pos, pos_nxt;
    logic          song, song_nxt;
    logic          play_q;
    logic          armed;
    logic          done_q, done_nxt;
    logic          advance;
    logic          start;
    logic          is_last;
    logic [5:0]    pos_inc;
    logic [5:0]    cur_entry;
    logic [5:0]    next_entry;
    logic [5:0]    first_sel_entry;
    logic [5:0]    first_song_entry;

    // Entry format: {code[3:0], beats[1:0]}; code 1..8 selects note_sw bit 8-code.
    function automatic logic [5:0] rom_entry(input logic sel, input logic [5:0] idx);
        logic [3:0] code;
        logic [1:0] beats;
        code  = 4'd0;
        beats = 2'd1;
        if (!sel) begin
            case (idx)
                6'd0, 6'd1, 6'd6, 6'd11, 6'd12,
                6'd15, 6'd16, 6'd21, 6'd26:               code = N_E;
                6'd2, 6'd5, 6'd17, 6'd20:                 code = N_F;
                6'd3, 6'd4, 6'd18, 6'd19:                 code = N_G;
                6'd7, 6'd10, 6'd13, 6'd14,
                6'd22, 6'd25, 6'd27:                      code = N_D;
                6'd8, 6'd9, 6'd23, 6'd24, 6'd28, 6'd29:   code = N_C;
                default:                                  code = 4'd0;
            endcase
            if (idx == 6'd14 || idx == 6'd29) beats = 2'd2;
        end else begin
            case (idx)
                6'd0, 6'd3, 6'd5:  code = N_C;
                6'd1:              code = N_D;
                6'd2, 6'd4, 6'd6:  code = N_E;
                default:           code = 4'd0;
            endcase
        end
        return {code, beats};
    endfunction

    function automatic logic [CW-1:0] note_load(input logic [5:0] entry);
        return CW'(entry[1:0]) * CW'(TICKS_PER_BEAT) - CW'(1);
    endfunction

    // Unused code 0 shifts the bit out entirely, giving silence.
    function automatic logic [7:0] decode(input logic [3:0] code);
        logic [3:0] sh;
        sh = 4'd8 - code;
        return 8'h01 << sh;
    endfunction

    assign pos_inc          = pos + 6'd1;
    assign cur_entry        = rom_entry(song, pos);
    assign next_entry       = rom_entry(song, pos_inc);
    assign first_sel_entry  = rom_entry(song_sel, 6'd0);
    assign first_song_entry = rom_entry(song, 6'd0);
    assign is_last          = (pos == (song ? LAST_SONG1 : LAST_SONG0));
    // armed keeps a play level held through reset from counting as a rising edge.
    assign start            = play && !play_q && armed;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pos_nxt   = pos;
        song_nxt  = song;
        done_nxt  = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = NOTE;
                    pos_nxt   = 6'd0;
                    song_nxt  = song_sel;
                    cnt_nxt   = note_load(first_sel_entry);
                end
            end
            NOTE: begin
                if (!play) begin
                    state_nxt = IDLE;
                    pos_nxt   = 6'd0;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    if (GAP_TICKS == 0) begin
                        advance = 1'b1;
                    end else begin
                        state_nxt = GAP;
                        cnt_nxt   = GAP_LOAD;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            GAP: begin
                if (!play) begin
                    state_nxt = IDLE;
                    pos_nxt   = 6'd0;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    advance = 1'b1;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                pos_nxt   = 6'd0;
                cnt_nxt   = '0;
            end
        endcase

        if (advance) begin
            if (is_last) begin
                done_nxt = 1'b1;
                pos_nxt  = 6'd0;
`ifdef SONG_PLAYER_LOOP_EN
                state_nxt = NOTE;
                cnt_nxt   = note_load(first_song_entry);
`else
                state_nxt = IDLE;
                cnt_nxt   = '0;
`endif
            end else begin
                state_nxt = NOTE;
                pos_nxt   = pos_inc;
                cnt_nxt   = note_load(next_entry);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            cnt    <= '0;
            pos    <= 6'd0;
            song   <= 1'b0;
            play_q <= 1'b0;
            armed  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            pos    <= pos_nxt;
            song   <= song_nxt;
            play_q <= play;
            done_q <= done_nxt;
            if (!play) armed <= 1'b1;
        end
    end

    assign note_sw  = (state == NOTE) ? decode(cur_entry[5:2]) : 8'h00;
    assign note_pos = pos;
    assign busy     = (state != IDLE);
    assign done     = done_q;

`ifndef SONG_PLAYER_LOOP_EN
    logic unused_first_song;
    assign unused_first_song = ^first_song_entry;
`endif

endmodule

// File: tb/tb_song_player.sv
// tb_song_player: checks song_player against a melody-level model of both songs.
// Honors SONG_PLAYER_LOOP_EN for the end-of-song behaviour.
module tb_song_player;
    localparam int TPB = 4;
    localparam int GAP = 1;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       play;
    logic       song_sel;
    logic [7:0] note_sw;
    logic [5:0] note_pos;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_sw[$];
    int         exp_pos[$];

    song_player #(.TICKS_PER_BEAT(TPB), .GAP_TICKS(GAP)) dut (
        .CLK(CLK), .RESET(RESET), .play(play), .song_sel(song_sel),
        .note_sw(note_sw), .note_pos(note_pos), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic string melody(input int s);
        return (s == 0) ? "EEFGGFEDCCDEEDDEEFGGFEDCCDEDCC" : "CDECECE";
    endfunction

    function automatic logic [7:0] onehot(input byte c);
        string scale;
        scale = "CDEFGAB";
        for (int i = 0; i < 7; i++) if (scale[i] == c) return 8'h80 >> i;
        return 8'h00;
    endfunction

    function automatic int beats_of(input int s, input int i);
        return (s == 0 && (i == 14 || i == 29)) ? 2 : 1;
    endfunction

    function automatic int total(input int s);
        int t;
        string m;
        m = melody(s);
        t = 0;
        for (int i = 0; i < m.len(); i++) t += beats_of(s, i) * TPB + GAP;
        return t;
    endfunction

    task automatic build(input int s);
        string m;
        m = melody(s);
        exp_sw.delete();
        exp_pos.delete();
        for (int i = 0; i < m.len(); i++) begin
            for (int k = 0; k < beats_of(s, i) * TPB; k++) begin
                exp_sw.push_back(onehot(m[i]));
                exp_pos.push_back(i);
            end
            for (int k = 0; k < GAP; k++) begin
                exp_sw.push_back(8'h00);
                exp_pos.push_back(i);
            end
        end
    endtask

    // Expects play low and sampled before the call; leaves play low and sampled.
    task automatic run_song(input int s, input int abort_at, input bit toggle,
                            input bit glitch, input int exp_busy);
        int busy_cnt;
        busy_cnt = 0;
        build(s);
        song_sel = s[0];
        play = 1'b1;
        for (int k = 0; k < exp_sw.size(); k++) begin
            step();
            chk("note_sw", note_sw, exp_sw[k]);
            chk("note_pos", note_pos, exp_pos[k]);
            chk("busy", busy, 1);
            chk("done_mid", done, 0);
            if (busy) busy_cnt++;
            if (toggle && k == 10) song_sel = ~song_sel;
            if (k == abort_at) begin
                play = 1'b0;
                step();
                chk("abort_sw", note_sw, 8'h00);
                chk("abort_busy", busy, 0);
                chk("abort_pos", note_pos, 0);
                chk("abort_done", done, 0);
                return;
            end
            if (glitch && $urandom_range(0, 5) == 0) begin
                play = 1'b0;
                #3;
                play = 1'b1;
            end
        end
        step();
`ifdef SONG_PLAYER_LOOP_EN
        chk("wrap_done", done, 1);
        chk("wrap_busy", busy, 1);
        chk("wrap_sw", note_sw, exp_sw[0]);
        chk("wrap_pos", note_pos, 0);
        play = 1'b0;
        step();
        chk("stop_busy", busy, 0);
        chk("stop_done", done, 0);
        chk("stop_sw", note_sw, 8'h00);
`else
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_sw", note_sw, 8'h00);
        step();
        chk("done_once", done, 0);
        chk("no_restart", busy, 0);
        play = 1'b0;
        step();
`endif
        if (exp_busy > 0) chk("busy_len", busy_cnt, exp_busy);
    endtask

    initial begin
        RESET    = 1'b1;
        play     = 1'b1;
        song_sel = 1'b0;
        repeat (3) step();
        RESET = 1'b0;
        step();
        chk("rst_sw", note_sw, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pos", note_pos, 0);
        repeat (3) begin
            step();
            chk("held_no_start", busy, 0);
        end
        play = 1'b0;
        step();

        run_song(0, -1, 1'b0, 1'b0, 158);
        run_song(1, -1, 1'b1, 1'b0, 35);
        run_song(0, 16, 1'b0, 1'b0, 0);
        run_song(0, -1, 1'b0, 1'b1, 158);

        play = 1'b1;
        repeat (8) step();
        chk("pre_reset_busy", busy, 1);
        RESET = 1'b1;
        step();
        chk("midrst_sw", note_sw, 8'h00);
        chk("midrst_busy", busy, 0);
        chk("midrst_pos", note_pos, 0);
        chk("midrst_done", done, 0);
        RESET = 1'b0;
        play  = 1'b0;
        step();
        chk("post_rst_idle", busy, 0);

        for (int r = 0; r < 4; r++) begin
            int s;
            int ab;
            s  = int'($urandom_range(0, 1));
            ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, total(s) - 2)) : -1;
            run_song(s, ab, bit'($urandom_range(0, 1)), 1'b1, (ab < 0) ? total(s) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
